// File: rtl/corrector_hamming_if.sv
// corrector_hamming_if: stream bus of the SECDED encoder/corrector.
// Input side: en_valido/en_listo handshake, modo, dato_in.
// Output side: sal_valido/sal_listo handshake, dato_out, sindrome, err_simple, err_doble.
// Status/control: cnt_simple, cnt_doble counters and limpiar_cnt clear.
// slave = the corrector, master = the producer/consumer driving it.
interface corrector_hamming_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
);
  function automatic int calc_p(input int dw);
    int r;
    r = 0;
    for (int p = 7; p >= 1; p--) if ((1 << p) >= dw + p + 1) r = p;
    return r;
  endfunction
  localparam int P = calc_p(DATA_W);
  localparam int N = DATA_W + P + 1;
  logic             en_valido;
  logic             en_listo;
  logic             modo;
  logic [N-1:0]     dato_in;
  logic             sal_valido;
  logic             sal_listo;
  logic [N-1:0]     dato_out;
  logic [P:0]       sindrome;
  logic             err_simple;
  logic             err_doble;
  logic [CNT_W-1:0] cnt_simple;
  logic [CNT_W-1:0] cnt_doble;
  logic             limpiar_cnt;
  modport slave (
    input  en_valido, modo, dato_in, sal_listo, limpiar_cnt,
    output en_listo, sal_valido, dato_out, sindrome, err_simple, err_doble, cnt_simple, cnt_doble
  );
  modport master (
    output en_valido, modo, dato_in, sal_listo, limpiar_cnt,
    input  en_listo, sal_valido, dato_out, sindrome, err_simple, err_doble, cnt_simple, cnt_doble
  );
endinterface

// File: rtl/corrector_hamming.sv
// corrector_hamming: two-stage SECDED Hamming encoder / corrector with saturating error counters.
// Ports: clk, rst (async, active-high), bus (corrector_hamming_if.slave).
// Stage 1 holds the word, its mode and the parity/syndrome; stage 2 holds the
// corrected output and classification. The whole pipe advances when stage 2
// is empty or being drained.
module corrector_hamming #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input logic               clk,
  input logic               rst,
  corrector_hamming_if.slave bus
);
  function automatic int calc_p(input int dw);
    int r;
    r = 0;
    for (int p = 7; p >= 1; p--) if ((1 << p) >= dw + p + 1) r = p;
    return r;
  endfunction
  localparam int P = calc_p(DATA_W);
  localparam int N = DATA_W + P + 1;
  localparam logic [P-1:0] S_MAX = P'(N - 1);
  // XOR of the Hamming positions of every set bit below the global parity bit
  function automatic logic [P-1:0] syn(input logic [N-1:0] w);
    logic [P-1:0] s;
    s = '0;
    for (int i = 1; i < N; i++) if (w[i-1]) s = s ^ P'(i);
    return s;
  endfunction
  // Parity bit 2^k equals bit k of the syndrome of the data-only word
  function automatic logic [N-1:0] enc(input logic [DATA_W-1:0] d);
    logic [N-1:0] c;
    logic [P-1:0] s;
    int j;
    c = '0;
    j = 0;
    for (int i = 1; i < N; i++)
      if ((i & (i - 1)) != 0) begin
        c[i-1] = d[j];
        j++;
      end
    s = syn(c);
    for (int k = 0; k < P; k++) c[(1 << k) - 1] = s[k];
    c[N-1] = ^c[N-2:0];
    return c;
  endfunction
  function automatic logic [DATA_W-1:0] dex(input logic [N-1:0] c);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 1; i < N; i++)
      if ((i & (i - 1)) != 0) begin
        d[j] = c[i-1];
        j++;
      end
    return d;
  endfunction
  logic             v1_q, m1_q, g1_q, v2_q, es_q, ed_q;
  logic             g1_d, es_d, ed_d;
  logic [N-1:0]     w1_q, w1_d, out_q, out_d, fix;
  logic [P-1:0]     s1_q, s1_d;
  logic [P:0]       sind_q, sind_d;
  logic [CNT_W-1:0] cs_q, cs_d, cd_q, cd_d;
  logic             adv, xfer, single, double;
  assign adv  = !v2_q || bus.sal_listo;
  assign xfer = v2_q && bus.sal_listo;
  always_comb begin
    w1_d   = bus.modo ? bus.dato_in : enc(bus.dato_in[DATA_W-1:0]);
    s1_d   = bus.modo ? syn(bus.dato_in) : '0;
    g1_d   = bus.modo && (^bus.dato_in);
    // A syndrome beyond the last position cannot be a single flip
    single = m1_q && g1_q && (s1_q <= S_MAX);
    double = m1_q && ((s1_q != '0 && !g1_q) || (g1_q && s1_q > S_MAX));
    fix    = (single && s1_q != '0) ? w1_q ^ (N'(1) << (s1_q - P'(1))) : w1_q;
    out_d  = m1_q ? N'(dex(fix)) : w1_q;
    sind_d = m1_q ? {g1_q, s1_q} : '0;
    es_d   = single;
    ed_d   = double;
    cs_d   = bus.limpiar_cnt ? '0 : (xfer && es_q && cs_q != '1) ? cs_q + CNT_W'(1) : cs_q;
    cd_d   = bus.limpiar_cnt ? '0 : (xfer && ed_q && cd_q != '1) ? cd_q + CNT_W'(1) : cd_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      m1_q   <= 1'b0;
      w1_q   <= '0;
      s1_q   <= '0;
      g1_q   <= 1'b0;
      v2_q   <= 1'b0;
      out_q  <= '0;
      sind_q <= '0;
      es_q   <= 1'b0;
      ed_q   <= 1'b0;
      cs_q   <= '0;
      cd_q   <= '0;
    end else begin
      if (adv) begin
        v1_q   <= bus.en_valido;
        m1_q   <= bus.modo;
        w1_q   <= w1_d;
        s1_q   <= s1_d;
        g1_q   <= g1_d;
        v2_q   <= v1_q;
        out_q  <= out_d;
        sind_q <= sind_d;
        es_q   <= es_d;
        ed_q   <= ed_d;
      end
      cs_q <= cs_d;
      cd_q <= cd_d;
    end
  end
  assign bus.en_listo   = adv;
  assign bus.sal_valido = v2_q;
  assign bus.dato_out   = out_q;
  assign bus.sindrome   = sind_q;
  assign bus.err_simple = es_q;
  assign bus.err_doble  = ed_q;
  assign bus.cnt_simple = cs_q;
  assign bus.cnt_doble  = cd_q;
endmodule

// File: tb/tb_corrector_hamming.sv
// tb_corrector_hamming: directed scoreboard bench for corrector_hamming (DATA_W=4, CNT_W=2).
module tb_corrector_hamming;
  typedef struct packed {
    logic [7:0] d;
    logic [3:0] s;
    logic       es;
    logic       ed;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t mon_a, mon_e;
  logic [7:0] held;
  corrector_hamming_if #(.DATA_W(4), .CNT_W(2)) bus ();
  corrector_hamming #(.DATA_W(4), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst && bus.sal_valido && bus.sal_listo) begin
      mon_a = {bus.dato_out, bus.sindrome, bus.err_simple, bus.err_doble};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got %h want none", mon_a);
      end else begin
        mon_e = q.pop_front();
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL word got d=%h s=%h es=%b ed=%b want d=%h s=%h es=%b ed=%b",
                   mon_a.d, mon_a.s, mon_a.es, mon_a.ed, mon_e.d, mon_e.s, mon_e.es, mon_e.ed);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic m, input logic [7:0] d, input exp_t e);
    int t;
    bus.en_valido = 1'b1;
    bus.modo      = m;
    bus.dato_in   = d;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.en_listo) break;
    end
    if (t == 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got en_listo=0 want 1");
    end else q.push_back(e);
    @(posedge clk);
    #1 bus.en_valido = 1'b0;
  endtask
  task automatic drain();
    for (int t = 0; t < 50 && q.size() != 0; t++) @(negedge clk);
    chk("drain_pending", q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.en_valido   = 1'b0;
    bus.modo        = 1'b0;
    bus.dato_in     = '0;
    bus.sal_listo   = 1'b1;
    bus.limpiar_cnt = 1'b0;
    #3;
    chk("rst_sal_valido", bus.sal_valido, 0);
    chk("rst_dato_out", bus.dato_out, 0);
    chk("rst_cnt_simple", bus.cnt_simple, 0);
    chk("rst_cnt_doble", bus.cnt_doble, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post_rst_en_listo", bus.en_listo, 1);
    send(1'b0, 8'h0B, '{8'h55, 4'h0, 1'b0, 1'b0});
    send(1'b1, 8'h55, '{8'h0B, 4'h0, 1'b0, 1'b0});
    send(1'b1, 8'h51, '{8'h0B, 4'hB, 1'b1, 1'b0});
    send(1'b1, 8'hD5, '{8'h0B, 4'h8, 1'b1, 1'b0});
    send(1'b1, 8'h56, '{8'h0B, 4'h3, 1'b0, 1'b1});
    send(1'b0, 8'h00, '{8'h00, 4'h0, 1'b0, 1'b0});
    send(1'b0, 8'h0F, '{8'hFF, 4'h0, 1'b0, 1'b0});
    send(1'b1, 8'h87, '{8'h01, 4'h0, 1'b0, 1'b0});
    drain();
    chk("cnt_simple_2", bus.cnt_simple, 2);
    chk("cnt_doble_1", bus.cnt_doble, 1);
    bus.sal_listo = 1'b0;
    fork
      begin
        send(1'b0, 8'h01, '{8'h87, 4'h0, 1'b0, 1'b0});
        send(1'b0, 8'h0F, '{8'hFF, 4'h0, 1'b0, 1'b0});
        send(1'b1, 8'h86, '{8'h01, 4'h9, 1'b1, 1'b0});
      end
      begin
        for (int t = 0; t < 20; t++) begin
          @(negedge clk);
          if (bus.sal_valido) break;
        end
        chk("stall_valid", bus.sal_valido, 1);
        held = bus.dato_out;
        chk("stall_first_word", held, 8'h87);
        repeat (3) begin
          @(negedge clk);
          chk("stall_hold", bus.dato_out, held);
          chk("stall_en_listo", bus.en_listo, 0);
        end
        @(posedge clk);
        #1 bus.sal_listo = 1'b1;
      end
    join
    drain();
    chk("cnt_simple_3", bus.cnt_simple, 3);
    bus.limpiar_cnt = 1'b1;
    @(posedge clk);
    #1 bus.limpiar_cnt = 1'b0;
    chk("clear_simple", bus.cnt_simple, 0);
    chk("clear_doble", bus.cnt_doble, 0);
    for (int i = 0; i < 5; i++) send(1'b1, 8'h51, '{8'h0B, 4'hB, 1'b1, 1'b0});
    drain();
    chk("sat_simple", bus.cnt_simple, 3);
    bus.limpiar_cnt = 1'b1;
    send(1'b1, 8'hD5, '{8'h0B, 4'h8, 1'b1, 1'b0});
    drain();
    bus.limpiar_cnt = 1'b0;
    chk("clear_over_inc", bus.cnt_simple, 0);
    send(1'b1, 8'h56, '{8'h0B, 4'h3, 1'b0, 1'b1});
    drain();
    chk("cnt_doble_pre_rst", bus.cnt_doble, 1);
    send(1'b0, 8'h0B, '{8'h55, 4'h0, 1'b0, 1'b0});
    send(1'b1, 8'h51, '{8'h0B, 4'hB, 1'b1, 1'b0});
    chk("inflight_valid", bus.sal_valido, 1);
    rst = 1'b1;
    q.delete();
    #1;
    chk("midrst_sal_valido", bus.sal_valido, 0);
    chk("midrst_cnt_simple", bus.cnt_simple, 0);
    chk("midrst_cnt_doble", bus.cnt_doble, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("midrst_en_listo", bus.en_listo, 1);
    repeat (6) @(posedge clk);
    #1 chk("no_stale_valid", bus.sal_valido, 0);
    send(1'b0, 8'h0B, '{8'h55, 4'h0, 1'b0, 1'b0});
    drain();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
